// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response handshake bundle for alu_issue.
//   req_valid/req_ready      request handshake
//   req_opcode, req_a, req_b operation code and operands
//   rsp_valid/rsp_ready      response handshake
//   rsp_hi, rsp_lo, rsp_err  captured result and reject flag
// Modports: master = control unit side, slave = alu_issue side.
interface alu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: operation sequencer and result collector for the combinational ALU.
// Accepts one request at a time, drives the ALU operand/opcode inputs, waits a
// per-class settle time, captures the 64-bit ALU result into HI/LO and presents
// it on a response handshake.
//
// Ports:
//   clk         clock, rising edge
//   clr         synchronous active-high reset
//   bus         alu_issue_if.slave: req_* in, req_ready out, rsp_* out, rsp_ready in
//   alu_y/alu_b operands to ALU Y_reg / B_reg
//   alu_opcode  opcode to ALU
//   alu_c       64-bit ALU result C_reg
//   busy        high whenever not idle
//
// Optional feature: define ALU_ISSUE_OPCHK_EN to reject opcodes 11011-11111 at
// accept (complete immediately with rsp_err=1). Undefined: rsp_err is tied 0.
module alu_issue #(
  parameter int unsigned ALU_WAIT    = 1,
  parameter int unsigned MULDIV_WAIT = 4
) (
  input  logic               clk,
  input  logic               clr,
  alu_issue_if.slave         bus,
  output logic [31:0]        alu_y,
  output logic [31:0]        alu_b,
  output logic [4:0]         alu_opcode,
  input  logic [63:0]        alu_c,
  output logic               busy
);

  localparam logic [4:0] OpMul  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpNop  = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11010;

  // Counter counts N-1 down to 0, so WAIT lasts exactly N cycles.
  localparam logic [3:0] AluLoad    = 4'(ALU_WAIT - 1);
  localparam logic [3:0] MulDivLoad = 4'(MULDIV_WAIT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] y_q, y_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  // Holds req_ready low until the first edge after clr deasserts.
  logic        init_q;

`ifdef ALU_ISSUE_OPCHK_EN
  logic        err_q, err_d;
  logic        reject;
`endif

  logic accept;
  logic is_imm;
  logic is_muldiv;

  assign bus.req_ready = (state_q == StIdle) && init_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign is_imm        = (bus.req_opcode == OpNop) || (bus.req_opcode == OpHalt);
  assign is_muldiv     = (bus.req_opcode == OpMul) || (bus.req_opcode == OpDiv);

`ifdef ALU_ISSUE_OPCHK_EN
  assign reject = (bus.req_opcode >= 5'b11011);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef ALU_ISSUE_OPCHK_EN
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_imm) begin
            hi_d    = '0;
            lo_d    = '0;
`ifdef ALU_ISSUE_OPCHK_EN
            err_d   = 1'b0;
`endif
            state_d = StResp;
`ifdef ALU_ISSUE_OPCHK_EN
          end else if (reject) begin
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
            state_d = StResp;
`endif
          end else begin
            y_d     = bus.req_a;
            b_d     = bus.req_b;
            op_d    = bus.req_opcode;
            cnt_d   = is_muldiv ? MulDivLoad : AluLoad;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          hi_d    = alu_c[63:32];
          lo_d    = alu_c[31:0];
`ifdef ALU_ISSUE_OPCHK_EN
          err_d   = 1'b0;
`endif
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      y_q     <= '0;
      b_q     <= '0;
      op_q    <= OpNop;
      hi_q    <= '0;
      lo_q    <= '0;
      init_q  <= 1'b0;
`ifdef ALU_ISSUE_OPCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      init_q  <= 1'b1;
`ifdef ALU_ISSUE_OPCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign alu_y         = y_q;
  assign alu_b         = b_q;
  assign alu_opcode    = op_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_lo    = lo_q;
  assign busy          = (state_q != StIdle);

`ifdef ALU_ISSUE_OPCHK_EN
  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk;
  logic        clr;
  logic [31:0] alu_y;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;
  logic        busy;

  int n_total;
  int n_pass;

  alu_issue_if bus ();

  alu_issue dut (
    .clk        (clk),
    .clr        (clr),
    .bus        (bus),
    .alu_y      (alu_y),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_c      (alu_c),
    .busy       (busy)
  );

  // Stand-in for the combinational datapath ALU (add, mul, div; others give 0).
  always_comb begin
    alu_c = '0;
    case (alu_opcode)
      5'b00011: alu_c = {32'd0, alu_y + alu_b};
      5'b01110: alu_c = {32'd0, alu_y} * {32'd0, alu_b};
      5'b01111: if (alu_b != 32'd0) alu_c = {alu_y % alu_b, alu_y / alu_b};
      default:  alu_c = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, then waits for rsp_valid. lat counts the accept edge as 1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_all);
    check("req_ready_before_issue", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    tick();
    // Scramble request fields after accept; they must have no effect.
    bus.req_valid  = 1'b0;
    bus.req_opcode = 5'b00011;
    bus.req_a      = 32'hdead_beef;
    bus.req_b      = 32'h1234_5678;
    lat      = 1;
    busy_all = busy;
    while (!bus.rsp_valid && lat < 40) begin
      tick();
      lat++;
      busy_all = busy_all & busy;
    end
  endtask

  task automatic respond();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic busy_all;
    logic saw_valid;

    n_total        = 0;
    n_pass         = 0;
    clr            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 5'd0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_alu_opcode", 64'(alu_opcode), 64'h19);
    check("rst_alu_yb", {alu_y, alu_b}, 64'd0);
    check("rst_rsp_hilo", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    clr = 1'b0;
    #1;
    check("req_ready_before_first_edge", 64'(bus.req_ready), 64'd0);
    tick();
    check("req_ready_after_clr", 64'(bus.req_ready), 64'd1);

    // Add 5 + 7
    issue(5'b00011, 32'd5, 32'd7, lat, busy_all);
    check("add_latency", 64'(lat), 64'd2);
    check("add_lo", 64'(bus.rsp_lo), 64'd12);
    check("add_hi", 64'(bus.rsp_hi), 64'd0);
    check("add_err", 64'(bus.rsp_err), 64'd0);
    check("add_alu_y", 64'(alu_y), 64'd5);
    check("add_alu_opcode", 64'(alu_opcode), 64'h03);
    respond();
    check("add_post_ready", 64'(bus.req_ready), 64'd1);
    check("add_post_valid", 64'(bus.rsp_valid), 64'd0);

    // Multiply 0x10000 * 0x10000 = 0x1_0000_0000
    issue(5'b01110, 32'h0001_0000, 32'h0001_0000, lat, busy_all);
    check("mul_latency", 64'(lat), 64'd5);
    check("mul_busy", 64'(busy_all), 64'd1);
    check("mul_hilo", {bus.rsp_hi, bus.rsp_lo}, 64'h0000_0001_0000_0000);
    respond();

    // Divide 100 / 7: HI=remainder 2, LO=quotient 14
    issue(5'b01111, 32'd100, 32'd7, lat, busy_all);
    check("div_latency", 64'(lat), 64'd5);
    check("div_hilo", {bus.rsp_hi, bus.rsp_lo}, {32'd2, 32'd14});
    respond();

    // Backpressure: add 100 + 23, response held 10 cycles, stray request ignored
    issue(5'b00011, 32'd100, 32'd23, lat, busy_all);
    check("bp_latency", 64'(lat), 64'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.req_valid  = 1'b1;
        bus.req_opcode = 5'b00011;
        bus.req_a      = 32'd1;
        bus.req_b      = 32'd1;
      end
      tick();
      check("bp_hold", {29'd0, bus.rsp_valid, bus.req_ready, busy, bus.rsp_lo},
            {29'd0, 1'b1, 1'b0, 1'b1, 32'd123});
    end
    check("bp_alu_y_kept", 64'(alu_y), 64'd100);
    bus.req_valid = 1'b0;
    respond();
    check("bp_ready_after_rsp", 64'(bus.req_ready), 64'd1);
    check("bp_valid_after_rsp", 64'(bus.rsp_valid), 64'd0);

    // Clear during WAIT of a divide
    bus.req_valid  = 1'b1;
    bus.req_opcode = 5'b01111;
    bus.req_a      = 32'd50;
    bus.req_b      = 32'd3;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check("clr_pre_busy", 64'(busy), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("clr_alu_opcode", 64'(alu_opcode), 64'h19);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      saw_valid = saw_valid | bus.rsp_valid;
    end
    check("clr_no_response", 64'(saw_valid), 64'd0);

    // Nop after an add: immediate completion, ALU inputs untouched
    issue(5'b00011, 32'd2, 32'd3, lat, busy_all);
    check("add2_lo", 64'(bus.rsp_lo), 64'd5);
    respond();
    issue(5'b11001, 32'd9, 32'd9, lat, busy_all);
    check("nop_latency", 64'(lat), 64'd1);
    check("nop_hilo", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    check("nop_alu_opcode", 64'(alu_opcode), 64'h03);
    check("nop_alu_y", 64'(alu_y), 64'd2);
    respond();

    // Halt
    issue(5'b11010, 32'd4, 32'd4, lat, busy_all);
    check("halt_latency", 64'(lat), 64'd1);
    check("halt_hilo", {bus.rsp_hi, bus.rsp_lo}, 64'd0);
    respond();

    // Add 8 + 9 then out-of-range opcode 11100
    issue(5'b00011, 32'd8, 32'd9, lat, busy_all);
    check("add3_lo", 64'(bus.rsp_lo), 64'd17);
    respond();
    issue(5'b11100, 32'd6, 32'd6, lat, busy_all);
    check("bad_lo", 64'(bus.rsp_lo), 64'd0);
`ifdef ALU_ISSUE_OPCHK_EN
    check("bad_latency", 64'(lat), 64'd1);
    check("bad_err", 64'(bus.rsp_err), 64'd1);
    check("bad_alu_opcode", 64'(alu_opcode), 64'h03);
    check("bad_alu_y", 64'(alu_y), 64'd8);
`else
    check("bad_latency", 64'(lat), 64'd2);
    check("bad_err", 64'(bus.rsp_err), 64'd0);
    check("bad_alu_opcode", 64'(alu_opcode), 64'h1c);
    check("bad_alu_y", 64'(alu_y), 64'd6);
`endif
    respond();

    // Follow-up add must report no error
    issue(5'b00011, 32'd1, 32'd1, lat, busy_all);
    check("add4_lo", 64'(bus.rsp_lo), 64'd2);
    check("add4_err", 64'(bus.rsp_err), 64'd0);
    respond();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
